// File: rtl/pcie_noc_scatter_pkg.sv
// Shared constants, flit layout helpers and FSM encodings for the PCIe-to-NoC
// scatter stage. The Def* values describe the default 2x2 host configuration.
package pcie_noc_scatter_pkg;

  localparam int DefX         = 2;
  localparam int DefY         = 2;
  localparam int DefDataWidth = 256;
  localparam int DefPckNum    = 8;
  localparam int DefSrcId     = 0;
  localparam int DefMaxOut    = 4;

  localparam int x_size      = $clog2(DefX);
  localparam int y_size      = $clog2(DefY);
  localparam int total_width = x_size + y_size + DefPckNum + DefDataWidth;

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    ISSUE       = 2'd1,
    HOLD        = 2'd2,
    WAIT_CREDIT = 2'd3
  } scatter_state_e;

  // Flit layout with x in the least significant bits.
  typedef struct packed {
    logic [DefDataWidth-1:0] data;
    logic [DefPckNum-1:0]    pckNo;
    logic [y_size-1:0]       y;
    logic [x_size-1:0]       x;
  } flit_t;

  function automatic logic [total_width-1:0] packFlit(
    input logic [DefDataWidth-1:0] data,
    input logic [DefPckNum-1:0]    pckNo,
    input logic [y_size-1:0]       y,
    input logic [x_size-1:0]       x
  );
    return {data, pckNo, y, x};
  endfunction

  function automatic flit_t unpackFlit(input logic [total_width-1:0] raw);
    return flit_t'(raw);
  endfunction

  // Linear node id is y*cols + x.
  function automatic int idToX(input int id, input int cols);
    return id % cols;
  endfunction

  function automatic int idToY(input int id, input int cols);
    return id / cols;
  endfunction

endpackage

// File: rtl/noc_skid_buffer.sv
// Two-entry valid/ready skid buffer. The ready output is registered and shows
// whether the buffer still has room after the current edge.
module noc_skid_buffer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid_i,
  input  logic [WIDTH-1:0] in_data_i,
  output logic             in_ready_o,
  output logic             out_valid_o,
  output logic [WIDTH-1:0] out_data_o,
  input  logic             out_pop_i
);

  logic [WIDTH-1:0] head_q;
  logic [WIDTH-1:0] tail_q;
  logic [1:0]       count_q;
  logic [1:0]       count_d;
  logic             ready_q;
  logic             push;
  logic             pop;

  // Occupancy bookkeeping for the current edge.
  always_comb begin
    push    = in_valid_i && ready_q;
    pop     = out_pop_i && (count_q != 2'd0);
    count_d = count_q;
    if (push && !pop) begin
      count_d = count_q + 2'd1;
    end else if (pop && !push) begin
      count_d = count_q - 2'd1;
    end
  end

  // Storage shifts toward the head on a pop; ready stays low until reset is released.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= 2'd0;
      ready_q <= 1'b0;
    end else begin
      count_q <= count_d;
      ready_q <= (count_d != 2'd2);
      if (pop) begin
        if (count_q == 2'd2) begin
          head_q <= tail_q;
        end else if (push) begin
          head_q <= in_data_i;
        end
      end else if (push) begin
        if (count_q == 2'd0) begin
          head_q <= in_data_i;
        end else begin
          tail_q <= in_data_i;
        end
      end
    end
  end

  assign in_ready_o  = ready_q;
  assign out_valid_o = (count_q != 2'd0);
  assign out_data_o  = head_q;

endmodule

// File: rtl/pcie_noc_scatter.sv
// PCIe ingress scatter: stamps each word with a wrapping packet number, picks
// the next round-robin PE and emits one credit-limited NoC flit per word.
module pcie_noc_scatter
  import pcie_noc_scatter_pkg::*;
#(
  parameter int X          = DefX,
  parameter int Y          = DefY,
  parameter int data_width = DefDataWidth,
  parameter int pck_num    = DefPckNum,
  parameter int SRC_ID     = DefSrcId,
  parameter int MAX_OUT    = DefMaxOut
) (
  input  logic                                             clk,
  input  logic                                             rst,
  input  logic                                             i_valid,
  input  logic [data_width-1:0]                            i_data,
  output logic                                             o_ready,
  output logic [$clog2(X)+$clog2(Y)+pck_num+data_width-1:0] o_flit,
  output logic                                             o_flit_valid,
  input  logic                                             i_flit_ready,
  input  logic [X*Y-1:0]                                   i_credit_ret,
  output logic                                             o_err
);

  localparam int NumNodes = X * Y;
  localparam int XW       = $clog2(X);
  localparam int YW       = $clog2(Y);
  localparam int IdW      = $clog2(NumNodes);
  localparam int EntryW   = data_width + pck_num;
  localparam int FlitW    = XW + YW + EntryW;
  localparam int CntW     = 4;
  localparam logic [IdW-1:0] FirstRr = (SRC_ID == 0) ? IdW'(1) : IdW'(0);

  // Next destination after cur, wrapping at the last node and never landing on the host.
  function automatic logic [IdW-1:0] advanceRr(input logic [IdW-1:0] cur);
    logic [IdW-1:0] nxt;
    nxt = (int'(cur) == NumNodes - 1) ? '0 : cur + 1'b1;
    if (int'(nxt) == SRC_ID) begin
      nxt = (int'(nxt) == NumNodes - 1) ? '0 : nxt + 1'b1;
    end
    return nxt;
  endfunction

  scatter_state_e      state_q;
  logic [IdW-1:0]      rr_q;
  logic [FlitW-1:0]    flit_q;
  logic                flitValid_q;
  logic [pck_num-1:0]  seq_q;
  logic [pck_num-1:0]  seq_d;
  logic [CntW-1:0]     credit_q [NumNodes];
  logic                err_q;

  logic                bufReady;
  logic                headValid;
  logic [EntryW-1:0]   headEntry;
  logic [CntW-1:0]     headCredit;
  logic                load;
  logic [XW-1:0]       rrX;
  logic [YW-1:0]       rrY;
  logic [NumNodes-1:0] creditDec;
  logic [NumNodes-1:0] creditInc;
  logic [NumNodes-1:0] badRet;

  noc_skid_buffer #(
    .WIDTH(EntryW)
  ) u_skid (
    .clk        (clk),
    .rst        (rst),
    .in_valid_i (i_valid),
    .in_data_i  ({i_data, seq_q}),
    .in_ready_o (bufReady),
    .out_valid_o(headValid),
    .out_data_o (headEntry),
    .out_pop_i  (load)
  );

  // Issue decision: head present, credit for the current PE, output free this edge.
  always_comb begin
    headCredit = credit_q[rr_q];
    load       = headValid && (state_q != WAIT_CREDIT) && (headCredit != '0) &&
                 (!flitValid_q || i_flit_ready);
    rrX        = XW'(idToX(int'(rr_q), X));
    rrY        = YW'(idToY(int'(rr_q), X));
    seq_d      = seq_q + 1'b1;
  end

  // Per-node credit events; a return is legal only if the counter has room after this edge.
  always_comb begin
    creditDec = '0;
    creditInc = '0;
    badRet    = '0;
    for (int n = 0; n < NumNodes; n++) begin
      creditDec[n] = load && (int'(rr_q) == n);
      creditInc[n] = i_credit_ret[n] && (n != SRC_ID) &&
                     ((credit_q[n] != CntW'(MAX_OUT)) || creditDec[n]);
      badRet[n]    = i_credit_ret[n] && !creditInc[n];
    end
  end

  // Packet number advances once per accepted word and wraps naturally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seq_q <= '0;
    end else if (i_valid && bufReady) begin
      seq_q <= seq_d;
    end
  end

  // Credit counters: simultaneous issue and return cancel out.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int n = 0; n < NumNodes; n++) begin
        credit_q[n] <= CntW'(MAX_OUT);
      end
    end else begin
      for (int n = 0; n < NumNodes; n++) begin
        if (creditInc[n] && !creditDec[n]) begin
          credit_q[n] <= credit_q[n] + 1'b1;
        end else if (creditDec[n] && !creditInc[n]) begin
          credit_q[n] <= credit_q[n] - 1'b1;
        end
      end
    end
  end

  // Sticky error for returns to a full counter or to the host node.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if (|badRet) begin
      err_q <= 1'b1;
    end
  end

  // Scatter FSM with registered flit, valid and round-robin pointer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      rr_q        <= FirstRr;
      flit_q      <= '0;
      flitValid_q <= 1'b0;
    end else begin
      if (load) begin
        flit_q      <= {headEntry, rrY, rrX};
        flitValid_q <= 1'b1;
        rr_q        <= advanceRr(rr_q);
      end else if (flitValid_q && i_flit_ready) begin
        flitValid_q <= 1'b0;
      end
      case (state_q)
        WAIT_CREDIT: begin
          if (headCredit != '0) begin
            state_q <= ISSUE;
          end
        end
        default: begin
          if (load) begin
            state_q <= ISSUE;
          end else if (flitValid_q && !i_flit_ready) begin
            state_q <= HOLD;
          end else if (headValid) begin
            state_q <= WAIT_CREDIT;
          end else begin
            state_q <= IDLE;
          end
        end
      endcase
    end
  end

  assign o_ready      = bufReady;
  assign o_flit       = flit_q;
  assign o_flit_valid = flitValid_q;
  assign o_err        = err_q;

endmodule

// File: tb/tb_pcie_noc_scatter.sv
// Directed bench for pcie_noc_scatter in its default 2x2 configuration with
// a word feeder, an optional credit-return sink and a flit scoreboard.
module tb_pcie_noc_scatter;
  import pcie_noc_scatter_pkg::*;

  localparam int FW = total_width;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          i_valid = 1'b0;
  logic [255:0]  i_data = '0;
  logic          o_ready;
  logic [FW-1:0] o_flit;
  logic          o_flit_valid;
  logic          i_flit_ready = 1'b1;
  logic [3:0]    i_credit_ret;
  logic          o_err;
  logic [3:0]    manualRet = 4'b0;
  logic [3:0]    autoRet = 4'b0;

  assign i_credit_ret = manualRet | autoRet;

  pcie_noc_scatter dut (
    .clk         (clk),
    .rst         (rst),
    .i_valid     (i_valid),
    .i_data      (i_data),
    .o_ready     (o_ready),
    .o_flit      (o_flit),
    .o_flit_valid(o_flit_valid),
    .i_flit_ready(i_flit_ready),
    .i_credit_ret(i_credit_ret),
    .o_err       (o_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]   pck;
    logic [255:0] data;
  } word_t;

  int           checkCount = 0;
  int           errorCount = 0;
  int           edgeCount = 0;
  int           wordId = 0;
  logic [255:0] sendQ[$];
  word_t        expQ[$];
  int           obsPck[$];
  int           obsX[$];
  int           obsY[$];
  int           hsEdge[$];
  int           acceptEdge[$];
  int           riseEdge[$];
  int           expSeq = 0;
  int           destIdx = 0;
  int           destOrder[3] = '{1, 2, 3};
  bit           acceptPending = 0;
  bit           autoReturn = 1;
  bit           autoRetPend = 0;
  int           autoRetDest = 0;
  bit           heldValid = 0;
  logic [FW-1:0] heldFlit = '0;
  bit           prevValid = 0;

  task automatic checkOutput(input string tag, input logic [299:0] got, input logic [299:0] exp);
    checkCount++;
    if (got !== exp) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input int n);
    for (int k = 0; k < n; k++) begin
      sendQ.push_back({8{32'(wordId)}});
      wordId++;
    end
  endtask

  task automatic doReset();
    rst = 1'b1;
    sendQ.delete();
    acceptPending = 0;
    autoRetPend = 0;
    manualRet = 4'b0;
    repeat (2) @(negedge clk);
    #2;
    rst = 1'b0;
  endtask

  task automatic waitDrain(input string tag, input int maxCycles);
    bit done = 0;
    for (int i = 0; i < maxCycles && !done; i++) begin
      tick();
      if (sendQ.size() == 0 && expQ.size() == 0 && !o_flit_valid) done = 1;
    end
    checkOutput(tag, done, 1);
  endtask

  task automatic waitFlitValid(input string tag, input int maxCycles);
    bit seen = 0;
    for (int i = 0; i < maxCycles && !seen; i++) begin
      tick();
      if (o_flit_valid) seen = 1;
    end
    checkOutput(tag, seen, 1);
  endtask

  always @(posedge clk) edgeCount <= edgeCount + 1;

  // Negedge monitor: scoreboard, stall stability and event logs for the next edge.
  always @(negedge clk) begin : monitor
    flit_t f;
    word_t w;
    int    d;
    acceptPending = 0;
    if (rst) begin
      expQ.delete();
      obsPck.delete(); obsX.delete(); obsY.delete();
      hsEdge.delete(); acceptEdge.delete(); riseEdge.delete();
      expSeq = 0;
      destIdx = 0;
      heldValid = 0;
      prevValid = 0;
    end else begin
      if (heldValid) checkOutput("flitStable", o_flit, heldFlit);
      heldValid = o_flit_valid && !i_flit_ready;
      heldFlit = o_flit;
      if (o_flit_valid && !prevValid) riseEdge.push_back(edgeCount);
      prevValid = o_flit_valid;
      if (o_flit_valid && i_flit_ready) begin
        f = unpackFlit(o_flit);
        obsPck.push_back(int'(f.pckNo));
        obsX.push_back(int'(f.x));
        obsY.push_back(int'(f.y));
        hsEdge.push_back(edgeCount + 1);
        d = destOrder[destIdx];
        destIdx = (destIdx + 1) % 3;
        checkOutput("sbHasEntry", expQ.size() != 0, 1);
        if (expQ.size() != 0) begin
          w = expQ.pop_front();
          checkOutput("sbPck", f.pckNo, w.pck);
          checkOutput("sbData", f.data, w.data);
          checkOutput("sbX", f.x, d % 2);
          checkOutput("sbY", f.y, d / 2);
        end
        if (autoReturn) begin
          autoRetPend = 1;
          autoRetDest = d;
        end
      end
      if (i_valid && o_ready) begin
        w.pck = expSeq[7:0];
        w.data = i_data;
        expQ.push_back(w);
        expSeq = (expSeq + 1) % 256;
        acceptEdge.push_back(edgeCount + 1);
        acceptPending = 1;
      end
    end
  end

  // Word feeder: presents the head of sendQ and drops it once accepted.
  initial begin
    forever begin
      tick();
      if (acceptPending && sendQ.size() > 0) void'(sendQ.pop_front());
      if (!rst && sendQ.size() > 0) begin
        i_valid = 1'b1;
        i_data = sendQ[0];
      end else begin
        i_valid = 1'b0;
      end
    end
  end

  // Credit sink: returns one credit the cycle after each handshake when enabled.
  initial begin
    forever begin
      tick();
      autoRet = (autoRetPend && !rst) ? 4'(1 << autoRetDest) : 4'b0;
      autoRetPend = 0;
    end
  end

  initial begin : stimulus
    int expXA[6] = '{1, 0, 1, 1, 0, 1};
    int expYA[6] = '{0, 1, 1, 0, 1, 1};
    int gaps;
    int wraps;
    flit_t f;

    // Reset values while reset is held.
    @(negedge clk);
    #1;
    checkOutput("rstReady", o_ready, 0);
    checkOutput("rstFlitValid", o_flit_valid, 0);
    checkOutput("rstFlit", o_flit, 0);
    checkOutput("rstErr", o_err, 0);
    #1;
    rst = 1'b0;
    checkOutput("readyBeforeEdge", o_ready, 0);
    tick();
    checkOutput("readyFirstEdge", o_ready, 1);

    // Six back-to-back words.
    $display("[TB] back-to-back stream");
    applyStimulus(6);
    waitDrain("drainA", 40);
    checkOutput("countA", obsPck.size(), 6);
    if (obsPck.size() == 6) begin
      for (int k = 0; k < 6; k++) begin
        checkOutput($sformatf("destXA%0d", k), obsX[k], expXA[k]);
        checkOutput($sformatf("destYA%0d", k), obsY[k], expYA[k]);
        checkOutput($sformatf("pckA%0d", k), obsPck[k], k);
      end
      checkOutput("firstLatency", riseEdge[0] - acceptEdge[0], 1);
      checkOutput("oneFlitPerCycle", hsEdge[5] - hsEdge[0], 5);
    end

    // Output stall mid-stream.
    $display("[TB] output stall");
    applyStimulus(10);
    repeat (3) tick();
    i_flit_ready = 1'b0;
    repeat (5) tick();
    checkOutput("stallReadyLow", o_ready, 0);
    checkOutput("stallFlitValid", o_flit_valid, 1);
    i_flit_ready = 1'b1;
    waitDrain("drainB", 60);
    checkOutput("countB", obsPck.size(), 16);

    // Long stream across the packet-number wrap.
    $display("[TB] 260-word stream");
    applyStimulus(260);
    waitDrain("drainC", 800);
    checkOutput("countC", obsPck.size(), 276);
    gaps = 0;
    wraps = 0;
    for (int k = 1; k < obsPck.size(); k++) begin
      if (obsPck[k] != (obsPck[k-1] + 1) % 256) gaps++;
      if (obsPck[k-1] == 255) wraps++;
    end
    checkOutput("pckGaps", gaps, 0);
    checkOutput("pckWraps", wraps, 1);

    // Credit corner cases: simultaneous issue/return on node 3, overflow on node 2.
    $display("[TB] credit corner cases");
    autoReturn = 0;
    i_flit_ready = 1'b0;
    doReset();
    tick();
    applyStimulus(3);
    repeat (8) tick();
    checkOutput("cornerReadyLow", o_ready, 0);
    checkOutput("cornerFlitValid", o_flit_valid, 1);
    i_flit_ready = 1'b1;
    tick();
    i_flit_ready = 1'b0;
    tick();
    i_flit_ready = 1'b1;
    manualRet = 4'b1000;
    tick();
    manualRet = 4'b0000;
    tick();
    checkOutput("credit3SameEdge", dut.credit_q[3], 4);
    checkOutput("errAfterSameEdge", o_err, 0);
    checkOutput("credit1Used", dut.credit_q[1], 3);
    manualRet = 4'b0100;
    tick();
    manualRet = 4'b0000;
    tick();
    checkOutput("credit2Returned", dut.credit_q[2], 4);
    checkOutput("errAfterLegalRet", o_err, 0);
    manualRet = 4'b0100;
    tick();
    manualRet = 4'b0000;
    tick();
    checkOutput("errOverflow", o_err, 1);
    checkOutput("credit2Unchanged", dut.credit_q[2], 4);
    waitDrain("drainD", 20);

    // Credit exhaustion: 12 flits fit, the 13th waits for node 1.
    $display("[TB] credit exhaustion");
    doReset();
    checkOutput("errClearedByReset", o_err, 0);
    applyStimulus(13);
    repeat (40) tick();
    checkOutput("exhaustCount", obsPck.size(), 12);
    checkOutput("exhaustNoFlit", o_flit_valid, 0);
    checkOutput("exhaustAccepted", sendQ.size(), 0);
    manualRet = 4'b0010;
    tick();
    manualRet = 4'b0000;
    waitFlitValid("releaseSeen", 5);
    f = unpackFlit(o_flit);
    checkOutput("releaseX", f.x, 1);
    checkOutput("releaseY", f.y, 0);
    checkOutput("releasePck", f.pckNo, 12);
    waitDrain("drainE", 20);

    // Reset with words buffered and a flit presented.
    $display("[TB] reset mid-operation");
    autoReturn = 1;
    i_flit_ready = 1'b0;
    doReset();
    tick();
    applyStimulus(3);
    repeat (8) tick();
    checkOutput("preRstFlitValid", o_flit_valid, 1);
    checkOutput("preRstReadyLow", o_ready, 0);
    #3;
    rst = 1'b1;
    #1;
    checkOutput("asyncDropValid", o_flit_valid, 0);
    checkOutput("asyncDropFlit", o_flit, 0);
    doReset();
    checkOutput("postRstReadyLow", o_ready, 0);
    i_flit_ready = 1'b1;
    tick();
    checkOutput("postRstReadyEdge", o_ready, 1);
    applyStimulus(1);
    waitFlitValid("postRstFlitSeen", 6);
    f = unpackFlit(o_flit);
    checkOutput("postRstPck", f.pckNo, 0);
    checkOutput("postRstX", f.x, 1);
    checkOutput("postRstY", f.y, 0);
    waitDrain("drainF", 20);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
